// File: rtl/circuit_reporter_window.sv
// Reporter-line measurement stage: synchronises and debounces out1/out2, then counts
// high cycles and rising edges of each filtered line over one WINDOW-sample window.
module circuit_reporter_window #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 9,
  parameter int STABLE = 3,
  parameter int EDGE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out1,
  input  logic              out2,
  input  logic              start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  high1,
  output logic [CNT_W-1:0]  high2,
  output logic [EDGE_W-1:0] rise1,
  output logic [EDGE_W-1:0] rise2
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_e;

  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int STAB_W = (STABLE > 1) ? $clog2(STABLE) : 1;

  localparam logic [WIN_W-1:0]  WIN_DONE  = WIN_W'(WINDOW);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;

  state_e             state_q, state_d;
  logic               clear_cnt, take_sample;
  logic [1:0]         raw;
  logic [1:0]         sync_a_q, sync_s_q, filt_q, filt_prev_q;
  logic [1:0]         rising;
  logic [STAB_W-1:0]  stab_q [2];
  logic [CNT_W-1:0]   high_q [2];
  logic [EDGE_W-1:0]  rise_q [2];
  logic [WIN_W-1:0]   win_q;

  assign raw    = {out2, out1};
  assign rising = filt_q & ~filt_prev_q;

  // Samples land on the edges where win_q is 0..WINDOW-1; the edge that sees
  // win_q == WINDOW only moves to HOLD, giving start-to-valid of WINDOW+1 cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_d     = state_q;
    clear_cnt   = 1'b0;
    take_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MEASURE;
          clear_cnt = 1'b1;
        end
      end
      MEASURE: begin
        if (win_q == WIN_DONE) begin
          state_d = HOLD;
        end else begin
          take_sample = 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (start) begin
            state_d   = MEASURE;
            clear_cnt = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      sync_a_q    <= '0;
      sync_s_q    <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      win_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        stab_q[i] <= '0;
        high_q[i] <= '0;
        rise_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sync_a_q    <= raw;
      sync_s_q    <= sync_a_q;
      filt_prev_q <= filt_q;

      // Debounce: the filtered value flips only after STABLE consecutive disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync_s_q[i] != filt_q[i]) begin
          if (stab_q[i] == STAB_LAST) begin
            filt_q[i] <= sync_s_q[i];
            stab_q[i] <= '0;
          end else begin
            stab_q[i] <= stab_q[i] + STAB_W'(1);
          end
        end else begin
          stab_q[i] <= '0;
        end
      end

      if (clear_cnt) begin
        win_q <= '0;
        for (int i = 0; i < 2; i++) begin
          high_q[i] <= '0;
          rise_q[i] <= '0;
        end
      end else if (take_sample) begin
        win_q <= win_q + WIN_W'(1);
        for (int i = 0; i < 2; i++) begin
          high_q[i] <= high_q[i] + CNT_W'(filt_q[i]);
          if (rising[i] && (rise_q[i] != EDGE_MAX)) begin
            rise_q[i] <= rise_q[i] + EDGE_W'(1);
          end
        end
      end
    end
  end

  assign busy      = (state_q == MEASURE);
  assign res_valid = (state_q == HOLD);
  assign high1     = high_q[0];
  assign high2     = high_q[1];
  assign rise1     = rise_q[0];
  assign rise2     = rise_q[1];

endmodule

// File: tb/tb_circuit_reporter_window.sv
// Directed bench for circuit_reporter_window: scoreboarded window results, handshake,
// glitch rejection, edge-count saturation (second instance) and mid-window reset.
module tb_circuit_reporter_window;

  localparam int WIN = 16;

  typedef struct {
    int h1;
    int h2;
    int r1;
    int r2;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic       rst, out1, out2, start, res_ready;
  logic       busy, res_valid;
  logic [4:0] high1, high2;
  logic [2:0] rise1, rise2;

  // saturation instance: STABLE=1 lets a line toggle every cycle
  logic       b_rst, b_out1, b_out2, b_start, b_res_ready;
  logic       b_busy, b_res_valid;
  logic [4:0] b_high1, b_high2;
  logic [1:0] b_rise1, b_rise2;

  res_t exp_q[$];
  res_t b_exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   ph = 0;

  circuit_reporter_window #(.WINDOW(WIN), .CNT_W(5), .STABLE(3), .EDGE_W(3)) dut (
    .clk(clk), .rst(rst), .out1(out1), .out2(out2), .start(start),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .high1(high1), .high2(high2), .rise1(rise1), .rise2(rise2)
  );

  circuit_reporter_window #(.WINDOW(WIN), .CNT_W(5), .STABLE(1), .EDGE_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .out1(b_out1), .out2(b_out2), .start(b_start),
    .busy(b_busy), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .high1(b_high1), .high2(b_high2), .rise1(b_rise1), .rise2(b_rise2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the edge that accepted start.
  task automatic start_main();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic accept(input logic restart);
    res_ready = 1'b1;
    start     = restart;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
  endtask

  // Waits (bounded) for res_valid, checks start-to-valid latency, pops and compares.
  task automatic wait_and_check(input string tag, input int elapsed);
    int   cyc;
    res_t e;
    cyc = elapsed;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_latency"}, cyc, WIN + 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_high1"}, high1, e.h1);
      check({tag, "_high2"}, high2, e.h2);
      check({tag, "_rise1"}, rise1, e.r1);
      check({tag, "_rise2"}, rise2, e.r2);
    end
  endtask

  // One cycle of square-wave stimulus: main out1 5-high/5-low, b_out1 toggling.
  task automatic tick_sq();
    out1   = ((ph % 10) < 5);
    b_out1 = ph[0];
    ph++;
    @(negedge clk);
  endtask

  initial begin
    res_t e;
    int   cyc;
    rst = 1'b1; out1 = 1'b0; out2 = 1'b0; start = 1'b0; res_ready = 1'b0;
    b_rst = 1'b1; b_out1 = 1'b0; b_out2 = 1'b0; b_start = 1'b0; b_res_ready = 1'b0;

    // 1: reset state, and idle stays quiet
    step(2);
    rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_high1", high1, 0);
    check("rst_high2", high2, 0);
    check("rst_rise1", rise1, 0);
    check("rst_rise2", rise2, 0);
    step(20);
    check("idle_busy", busy, 0);
    check("idle_valid", res_valid, 0);
    check("idle_high1", high1, 0);

    // 2: out1 steady high before and during the window
    out1 = 1'b1;
    step(10);
    exp_q.push_back('{h1: WIN, h2: 0, r1: 0, r2: 0});
    start_main();
    check("t2_busy", busy, 1);
    wait_and_check("t2", 0);

    // 5: held result ignores start without res_ready
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_busy", busy, 0);
      check("hold_high1", high1, WIN);
      check("hold_rise1", rise1, 0);
    end
    start = 1'b0;
    exp_q.push_back('{h1: WIN, h2: 0, r1: 0, r2: 0});
    accept(1'b1);
    check("restart_valid", res_valid, 0);
    check("restart_busy", busy, 1);
    check("restart_high1", high1, 0);
    wait_and_check("t5", 0);
    accept(1'b0);
    check("release_valid", res_valid, 0);
    check("release_busy", busy, 0);

    // 3: 2-cycle glitch is filtered, 6-cycle pulse is counted once
    out1 = 1'b0;
    step(8);
    exp_q.push_back('{h1: 0, h2: 6, r1: 0, r2: 1});
    start_main();
    out2 = 1'b1;
    step(2);
    out2 = 1'b0;
    step(3);
    out2 = 1'b1;
    step(6);
    out2 = 1'b0;
    wait_and_check("t3", 11);
    accept(1'b0);

    // 4: continuous square waves over 4 back-to-back windows
    repeat (12) tick_sq();
    start = 1'b1;
    b_start = 1'b1;
    tick_sq();
    start = 1'b0;
    b_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      b_exp_q.push_back('{h1: WIN / 2, h2: 0, r1: 3, r2: 0});
      cyc = 0;
      while (!res_valid && cyc < 200) begin
        tick_sq();
        cyc++;
      end
      check("sq_valid", res_valid, 1);
      check_range("sq_high1", int'(high1), 6, 10);
      check_range("sq_rise1", int'(rise1), 1, 2);
      check("sq_high2", high2, 0);
      check("sat_valid", b_res_valid, 1);
      e = b_exp_q.pop_front();
      check("sat_high1", b_high1, e.h1);
      check("sat_rise1", b_rise1, e.r1);
      check("sat_high2", b_high2, e.h2);
      check("sat_rise2", b_rise2, e.r2);
      res_ready = 1'b1;
      b_res_ready = 1'b1;
      start = (w < 3);
      b_start = (w < 3);
      tick_sq();
      res_ready = 1'b0;
      b_res_ready = 1'b0;
      start = 1'b0;
      b_start = 1'b0;
    end
    check("sq_end_valid", res_valid, 0);
    check("sq_end_busy", busy, 0);

    // 6: reset mid-window discards it; the next start gives a full window
    out1 = 1'b1;
    step(8);
    start_main();
    step(8);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_high1", high1, 0);
    check("midrst_rise1", rise1, 0);
    step(8);
    exp_q.push_back('{h1: WIN, h2: 0, r1: 0, r2: 0});
    start_main();
    wait_and_check("t6", 0);
    accept(1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/circuit_reporter_window.md
Name: circuit_reporter_window

Overview:
- Downstream measurement stage for the two-output genetic logic circuit (reporters out1/out2).
- Synchronises and debounces both reporter lines, then measures each over a fixed window of clock cycles.
- Per line, it counts high cycles and rising edges over the window.
- Presents the four results to a readout consumer over a valid/ready handshake. One window per start request.

Parameters:
- WINDOW, 256: samples per measurement window (>=2).
- CNT_W, 9: width of high-time counters; must satisfy 2^CNT_W > WINDOW.
- STABLE, 3: consecutive agreeing synchronised samples required to change a filtered value (>=1).
- EDGE_W, 6: width of rising-edge counters; saturating.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- out1  input  1  reporter line 1 from the logic circuit; asynchronous to clk.
- out2  input  1  reporter line 2 from the logic circuit; asynchronous to clk.
- start  input  1  request a measurement; sampled in IDLE, or in HOLD during the handshake cycle.
- busy  output  1  high while in MEASURE.
- res_valid  output  1  result available (HOLD).
- res_ready  input  1  consumer accepts result.
- high1  output  CNT_W  cycles filtered out1 was 1 during the window.
- high2  output  CNT_W  cycles filtered out2 was 1 during the window.
- rise1  output  EDGE_W  rising edges of filtered out1 in the window.
- rise2  output  EDGE_W  rising edges of filtered out2 in the window.

Behaviour:
- Reset (rst=1 at a clk edge), effective that edge:
  - state=IDLE; busy=0, res_valid=0.
  - high1/high2/rise1/rise2=0.
  - sync flops=0; filtered values f1=f2=0; stability counters=0; window counter=0.
  - rst overrides start/res_ready. Reset mid-MEASURE or mid-HOLD discards the window.
- Input path, per line, runs in all states:
  - 2-flop synchroniser produces s.
  - If s != f for STABLE consecutive cycles, f takes s on the STABLE-th such edge and the stability counter clears.
  - Any cycle with s == f clears the stability counter.
  - Pulses of fewer than STABLE synchronised cycles never reach f.
  - Raw change to f change: 2+STABLE cycles.
- f_prev is f delayed one cycle. A rising edge is f=1 & f_prev=0. f_prev tracks continuously, so an edge spanning window start counts if f rises on a sampled cycle.
- IDLE:
  - busy=0, res_valid=0.
  - start=1 -> MEASURE next cycle; clear high/rise counters and window counter.
- MEASURE:
  - busy=1. Each cycle is one sample.
  - highN += fN.
  - riseN += (fN & ~f_prevN), saturating at 2^EDGE_W-1.
  - Window counter increments.
  - On the WINDOW-th sample -> HOLD. The first sample is the first cycle in MEASURE.
  - start is ignored.
  - Result outputs are not meaningful while busy=1; they may show running values.
- HOLD:
  - res_valid=1, busy=0; outputs frozen.
  - res_valid stays high and values are stable until res_ready=1.
  - res_valid=1 & res_ready=1 -> IDLE, or -> MEASURE if start=1 in the same cycle (counters cleared). res_valid deasserts next cycle either way.
  - start without res_ready is ignored.
- Arithmetic:
  - highN <= WINDOW by construction; no overflow.
  - riseN saturates and never wraps.
- Latency: start accepted to res_valid = WINDOW+1 cycles. Example: start at edge 0 gives res_valid high after edge WINDOW+1.

Test Plan (WINDOW=16, STABLE=3, CNT_W=5, EDGE_W=3):
1. rst held 2 cycles, then released, start=0 -> busy=0, res_valid=0, all counts 0; still 0 after 20 cycles.
2. out1=1, out2=0 held for 10 cycles, then start pulse -> res_valid high 17 cycles after start, high1=16, high2=0, rise1=0, rise2=0.
3. Mid-window, out2 gets a 2-cycle high glitch, then a 6-cycle high pulse with both lows >=3 cycles -> high2=6, rise2=1; glitch not counted.
4. out1 toggles 5 cycles high / 5 low continuously over 4 windows, then 5 rising edges forced inside one window with EDGE_W=2 -> rise1 saturates at 3, high1 <= 16, never wraps.
5. Result held with res_ready=0 for 10 cycles, start pulsed meanwhile -> res_valid and values unchanged, start ignored. Then res_ready=1 & start=1 together -> res_valid=0 and busy=1 next cycle, new window counts from 0.
6. rst asserted 8 samples into MEASURE -> next cycle busy=0, res_valid=0, counts 0. A following start produces a full 16-sample window.
